// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchronizer, oversampled bit timing, valid/ready output.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int  DW         = 8,
    parameter real CLOCK      = 100e6,
    parameter real BAUD_RATE  = 115200,
    parameter int  OVERSAMPLE = 16,
    parameter int  TICK_DIV   = int'($floor(CLOCK / (BAUD_RATE * OVERSAMPLE))),
    parameter bit  PARITY_ODD = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    output logic [DW-1:0] data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic          frame_err_o,
    output logic          overrun_err_o,
    output logic          parity_err_o,
    output logic          busy_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          perr_q, perr_d;
    logic          par_bad_q, par_bad_d;

    logic rxs, tick, half_end, bit_end, stop_smp, blocked, load;

    assign rxs      = sync_q[1];
    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign half_end = tick && (samp_q == SW'(OVERSAMPLE / 2 - 1));
    assign bit_end  = tick && (samp_q == SW'(OVERSAMPLE - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            presc_q   <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            state_q   <= state_d;
            presc_q   <= presc_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rxs) state_d = START;
            START:  if (half_end) state_d = rxs ? IDLE : DATA;
            DATA:   if (bit_end && bit_q == BW'(DW - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) state_d = rxs ? IDLE : BRK;
            BRK:    if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A byte is refused only when the previous one is still held and not taken this cycle.
    assign stop_smp = (state_q == STOP) && bit_end;
    assign blocked  = valid_q && !rx_ready_i;
    assign load     = stop_smp && rxs && !par_bad_q && !blocked;

    always_comb begin
        busy_o    = (state_q != IDLE);
        presc_d   = (state_q == IDLE || tick) ? '0 : presc_q + 1'b1;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        if (state_q == IDLE || state_q == BRK || state_d != state_q)
            samp_d = '0;
        else if (tick)
            samp_d = (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + 1'b1;
        if (state_q != DATA)
            bit_d = '0;
        else if (bit_end)
            bit_d = bit_q + 1'b1;
        if (state_q == DATA && bit_end)
            shift_d = {rxs, shift_q[DW-1:1]};
        if (state_q == IDLE)
            par_bad_d = 1'b0;
        else if (state_q == PARITY && bit_end)
            par_bad_d = ((^shift_q) ^ PARITY_ODD) != rxs;
        ferr_d  = stop_smp && !rxs;
        perr_d  = stop_smp && rxs && par_bad_q;
        ovr_d   = stop_smp && rxs && !par_bad_q && blocked;
        data_d  = load ? shift_q : data_q;
        valid_d = load ? 1'b1 : (valid_q && !rx_ready_i);
    end

    assign data_o        = data_q;
    assign rx_valid_o    = valid_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = perr_q;
`else
    assign parity_err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 cycles per bit: directed frames plus a randomized frame stream
// checked against a frame-level outcome model.
module tb_uart_rx;
    localparam int DW  = 8;
    localparam int BIT = 16;
    localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int STOP_IDX = 1 + DW + int'(PAR_EN);
    // drive edge -> first DUT edge, stop centre, two sync flops incl. sample, output register
    localparam int LAT = 1 + STOP_IDX * BIT + BIT / 2 + 2;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rdy = 1'b0;
    logic [DW-1:0] data;
    logic vld, ferr, ovr, perr, busy;

    uart_rx #(.DW(DW), .CLOCK(16e6), .BAUD_RATE(1e6), .OVERSAMPLE(16), .PARITY_ODD(PAR_ODD)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .data_o(data), .rx_valid_o(vld),
        .rx_ready_i(rdy), .frame_err_o(ferr), .overrun_err_o(ovr),
        .parity_err_o(perr), .busy_o(busy));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0, last_rise = -1;
    logic vld_prev = 1'b0, rnd_on = 1'b0, rdone = 1'b0;
    logic [DW-1:0] got_q[$], exp_q[$];
    int start_cyc, exp_perr = 0;

    always @(negedge clk) begin
        if (ferr) n_ferr++;
        if (ovr)  n_ovr++;
        if (perr) n_perr++;
        if (vld && !vld_prev) begin n_rise++; last_rise = cyc; end
        vld_prev = vld;
        if (rnd_on && vld && rdy) got_q.push_back(data);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level; caller decides what follows.
    task automatic send(input logic [DW-1:0] b, input logic stop_ok, input logic pflip);
        start_cyc = cyc;
        line(1'b0, BIT);
        for (int i = 0; i < DW; i++) line(b[i], BIT);
        if (PAR_EN) line((^b) ^ PAR_ODD ^ pflip, BIT);
        line(stop_ok, BIT);
    endtask

    task automatic accept();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("accept_clears", vld, 0);
    endtask

    // Frame-level outcome: 0 byte delivered, 1 framing, 2 parity, 3 overrun.
    function automatic int outcome(input logic stop_ok, input logic pflip, input logic pending);
        if (!stop_ok) return 1;
        if (PAR_EN && pflip) return 2;
        if (pending) return 3;
        return 0;
    endfunction

    initial begin
        int f0, o0, p0, r0, ef, ep;
        logic [DW-1:0] b;
        logic sok, pf;

        repeat (3) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_valid", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {ferr, ovr, perr}, 0);
        rst = 1'b0;
        line(1'b1, 5);

        // 0xA5 with exact latency
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr; r0 = n_rise;
        send(8'hA5, 1'b1, 1'b0);
        line(1'b1, 4);
        chk("a5_latency", last_rise - start_cyc, LAT);
        chk("a5_data", data, 8'hA5);
        chk("a5_valid", vld, 1);
        chk("a5_busy", busy, 0);
        chk("a5_errs", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
        accept();

        // short low glitch on idle line
        r0 = n_rise; f0 = n_ferr;
        line(1'b0, 4);
        chk("glitch_busy_hi", busy, 1);
        line(1'b1, 8);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_no_valid", n_rise - r0, 0);
        chk("glitch_no_err", n_ferr - f0, 0);

        // framing error followed by a held-low line
        f0 = n_ferr; r0 = n_rise;
        send(8'h3C, 1'b0, 1'b0);
        line(1'b0, 40);
        chk("ferr_once", n_ferr - f0, 1);
        chk("ferr_brk_busy", busy, 1);
        line(1'b1, 30);
        chk("ferr_no_retrig", busy, 0);
        chk("ferr_still_once", n_ferr - f0, 1);
        chk("ferr_no_valid", n_rise - r0, 0);
        send(8'h55, 1'b1, 1'b0);
        line(1'b1, 4);
        chk("after_ferr_data", data, 8'h55);
        chk("after_ferr_valid", vld, 1);
        accept();

        // overrun on back-to-back frames
        o0 = n_ovr;
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        line(1'b1, 4);
        chk("ovr_once", n_ovr - o0, 1);
        chk("ovr_data_kept", data, 8'h11);
        chk("ovr_valid", vld, 1);
        accept();

        // reset pulse in data bit 3
        r0 = n_rise;
        fork
            send(8'hFF, 1'b1, 1'b0);
            begin
                repeat (BIT * 4 + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_data", data, 0);
                chk("midrst_valid", vld, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_errs", {ferr, ovr, perr}, 0);
            end
        join
        line(1'b1, 20);
        chk("midrst_no_valid", n_rise - r0, 0);
        send(8'h81, 1'b1, 1'b0);
        line(1'b1, 4);
        chk("after_rst_data", data, 8'h81);
        chk("after_rst_valid", vld, 1);
        accept();

`ifdef UART_RX_PARITY_EN
        p0 = n_perr; r0 = n_rise;
        send(8'h07, 1'b1, 1'b1);
        line(1'b1, 4);
        exp_perr++;
        chk("par_err_once", n_perr - p0, 1);
        chk("par_err_no_valid", n_rise - r0, 0);
        send(8'h07, 1'b1, 1'b0);
        line(1'b1, 4);
        chk("par_ok_data", data, 8'h07);
        chk("par_ok_valid", vld, 1);
        accept();
`endif

        // randomized stream with random consumer back-pressure
        f0 = n_ferr; o0 = n_ovr; ef = 0; ep = 0;
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    b   = DW'($urandom);
                    sok = ($urandom % 6) != 0;
                    pf  = ($urandom % 5) == 0;
                    case (outcome(sok, pf, 1'b0))
                        0: exp_q.push_back(b);
                        1: ef++;
                        2: ep++;
                        default: ;
                    endcase
                    send(b, sok, pf);
                    if (!sok) line(1'b0, int'($urandom_range(0, 20)));
                    line(1'b1, int'($urandom_range(3, 40)));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #2 rdy = $urandom % 2;
                end
            end
        join
        @(posedge clk);
        #2 rdy = 1'b1;
        repeat (4) @(negedge clk);
        rdy = 1'b0;
        rnd_on = 1'b0;
        exp_perr += ep;
        chk("rnd_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rnd_byte%0d", i), got_q[i], exp_q[i]);
        chk("rnd_ferr", n_ferr - f0, ef);
        chk("rnd_ovr", n_ovr - o0, 0);
        chk("perr_total", n_perr, exp_perr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the counterpart of the team's uart_tx. Frame format: 8N1 by default, 1 start bit (low), DW data bits LSB first, 1 stop bit (high).
- Oversamples rx_i, qualifies the start bit at mid-bit and samples each bit at its centre.
- Presents each received byte on a valid/ready handshake toward the fabric.
- Flags framing errors and overrun errors. Parity checking is optional.

Parameters:
- DW, 8, data bits per frame.
- CLOCK, 100e6, clk_i frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 4.
- TICK_DIV, CLOCK/(BAUD_RATE*OVERSAMPLE) truncated, clk_i cycles per sample tick; must be at least 1.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only with UART_RX_PARITY_EN.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- rx_i  in  1  asynchronous serial line; idles high.
- data_o  out  DW  last accepted byte.
- rx_valid_o  out  1  data_o holds an unconsumed byte.
- rx_ready_i  in  1  consumer accepts data_o.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err_o  out  1  one-cycle pulse: byte completed while rx_valid_o was still high.
- parity_err_o  out  1  one-cycle pulse: parity mismatch.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - Outputs: data_o=0, rx_valid_o=0, all error pulses 0, busy_o=0.
  - Internals: both synchronizer flops set to 1, state=IDLE, all counters 0.
  - A reset asserted mid-frame abandons the frame and leaves no partial byte.
- Synchronizer: 2-flop synchronizer on rx_i. All logic uses its output rxs, so there is 2 cycles of input latency.
- Tick generator:
  - Prescaler counts 0..TICK_DIV-1. tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - The prescaler is cleared in the cycle IDLE->START, so the first tick falls TICK_DIV cycles later.
- Sample counter: counts ticks 0..OVERSAMPLE-1. Bit counter: counts 0..DW-1.
- FSM:
  - IDLE: when rxs=0, go to START and clear the sample counter.
  - START: after OVERSAMPLE/2 ticks, sample rxs.
    - rxs=0: go to DATA and clear the sample counter.
    - rxs=1: glitch; return to IDLE with no error.
  - DATA: every OVERSAMPLE ticks, shift rxs into the shift register MSB, shifting right. After the bit counter reaches DW-1, go to PARITY if enabled, else STOP.
  - PARITY (optional): after OVERSAMPLE ticks, sample the parity bit and latch the mismatch result; go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rxs.
    - rxs=0: pulse frame_err_o, discard the byte, go to BREAK.
    - rxs=1 with parity mismatch: pulse parity_err_o, discard the byte, go to IDLE.
    - rxs=1 with rx_valid_o=1 and no rx_ready_i that cycle: pulse overrun_err_o, discard the new byte (data_o keeps the old byte), go to IDLE.
    - otherwise: load data_o, set rx_valid_o the next cycle, go to IDLE.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents retriggering on a held-low line.
- Handshake:
  - rx_valid_o stays high until a cycle with rx_valid_o & rx_ready_i; it clears on the following edge.
  - A byte completing in the same cycle as the accept is loaded with no overrun, and rx_valid_o stays high.
  - data_o is stable while rx_valid_o=1.
- Latency: rx_valid_o rises 1 cycle after the stop-bit centre sample.
- Priority on simultaneous conditions: frame error > parity error > overrun. Only one error pulse is asserted per frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA. The expected parity is XOR of the data bits XOR PARITY_ODD, and parity_err_o is live.
- Undefined: no PARITY state, the frame is start + DW + stop, and parity_err_o is tied to 0. The port list is identical in both builds.

Test Plan:
- Bench parameters for all scenarios: CLOCK=16e6, BAUD_RATE=1e6, OVERSAMPLE=16, which gives TICK_DIV=1 and a bit time of 16 cycles.
- Byte 0xA5, then idle -> rx_valid_o=1 with data_o=0xA5 one cycle after the stop-bit centre. busy_o is low on the next cycle. No errors.
- Low glitch of 4 cycles on idle line -> no rx_valid_o, no errors, FSM back in IDLE, busy_o=0 within 12 cycles.
- Frame 0x3C with stop bit driven low, line then held low for 40 cycles -> frame_err_o pulses once, rx_valid_o stays 0. No retrigger until the line goes high. A following 0x55 is received correctly.
- Two back-to-back bytes 0x11 then 0x22 with rx_ready_i=0 -> data_o=0x11 held, overrun_err_o pulses once at the second stop bit. Asserting rx_ready_i then clears rx_valid_o.
- rst_i asserted for 1 cycle during data bit 3 of 0xFF -> all outputs 0 and no rx_valid_o for that frame. The next 0x81 is received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0, byte 0x07 sent with parity bit 0 -> parity_err_o pulses and no rx_valid_o. Same byte with parity bit 1 -> data_o=0x07 and rx_valid_o=1.
